// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter: round-robin burst arbiter in front of one shared
// synchronous single-port ROM (registered read data, 1-cycle latency).
// Each grant issues one ROM word per cycle and returns tagged read data.
// Build option: define ROM_BURST_ARB_RSP_REG_EN to add one register stage
// on the response outputs (response latency 2 instead of 1).
//
// state | meaning
// IDLE  | no burst open; grants a request and issues its word 0
// BURST | issuing words 1..len of the granted burst, one per cycle
module rom_burst_arbiter #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 128,
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ*AW-1:0]  i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [AW-1:0]          o_rom_addr,
  input  logic [WIDTH-1:0]       i_rom_dout,
  output logic                   o_rsp_valid,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [WIDTH-1:0]       o_rsp_data,
  output logic                   o_rsp_last,
  output logic                   o_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    cur_addr, cur_addr_nx;
  logic [LEN_W-1:0] remaining, remaining_nx;
  logic [IDW-1:0]   owner, owner_nx;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nx;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [AW-1:0]    win_addr;
  logic [LEN_W-1:0] win_len;

  logic             issue_v, issue_last;
  logic [IDW-1:0]   issue_id;
  logic             issue_v_d, last_d;
  logic [IDW-1:0]   id_d;
  logic [WIDTH-1:0] rsp_data_c;

  // Wrap by explicit compare so non-power-of-two depths stay in range.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    win_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && i_req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
        win_addr  = i_req_addr[idx*AW +: AW];
        win_len   = i_req_len[idx*LEN_W +: LEN_W];
      end
    end
  end

  // FSM state and burst bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      issue_v_d <= 1'b0;
      id_d      <= '0;
      last_d    <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_addr  <= cur_addr_nx;
      remaining <= remaining_nx;
      owner     <= owner_nx;
      rr_ptr    <= rr_ptr_nx;
      issue_v_d <= issue_v;
      id_d      <= issue_id;
      last_d    <= issue_last;
    end
  end

  // Next-state, grant and ROM issue decode. Grants are gated by i_rst_n so
  // no ready pulse escapes while reset is held.
  always_comb begin
    state_nx     = state;
    cur_addr_nx  = cur_addr;
    remaining_nx = remaining;
    owner_nx     = owner;
    rr_ptr_nx    = rr_ptr;
    o_req_ready  = '0;
    o_rom_addr   = '0;
    issue_v      = 1'b0;
    issue_id     = '0;
    issue_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rst_n && win_found) begin
          o_req_ready[win_id] = 1'b1;
          o_rom_addr = win_addr;
          issue_v    = 1'b1;
          issue_id   = win_id;
          issue_last = (win_len == '0);
          rr_ptr_nx  = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
          if (win_len != '0) begin
            state_nx     = S_BURST;
            cur_addr_nx  = addr_inc(win_addr);
            remaining_nx = win_len;
            owner_nx     = win_id;
          end
        end
      end
      S_BURST: begin
        o_rom_addr   = cur_addr;
        issue_v      = 1'b1;
        issue_id     = owner;
        issue_last   = (remaining == LEN_W'(1));
        cur_addr_nx  = addr_inc(cur_addr);
        remaining_nx = remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign o_busy = (state == S_BURST);

  // ROM data is passed through only alongside a valid word, so idle and
  // reset cycles show 0 instead of stale ROM output.
  assign rsp_data_c = issue_v_d ? i_rom_dout : '0;

`ifdef ROM_BURST_ARB_RSP_REG_EN
  // Extra output stage on the response path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
      o_rsp_last  <= 1'b0;
    end else begin
      o_rsp_valid <= issue_v_d;
      o_rsp_id    <= id_d;
      o_rsp_data  <= rsp_data_c;
      o_rsp_last  <= last_d;
    end
  end
`else
  assign o_rsp_valid = issue_v_d;
  assign o_rsp_id    = id_d;
  assign o_rsp_data  = rsp_data_c;
  assign o_rsp_last  = last_d;
`endif

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Table-driven bench for rom_burst_arbiter (WIDTH=8, DEPTH=128, NUM_REQ=2).
module tb_rom_burst_arbiter;

`ifdef ROM_BURST_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_req_valid = '0;
  logic [13:0] i_req_addr = '0;
  logic [7:0]  i_req_len = '0;
  logic [1:0]  o_req_ready;
  logic [6:0]  o_rom_addr;
  logic [7:0]  i_rom_dout = '0;
  logic        o_rsp_valid;
  logic        o_rsp_id;
  logic [7:0]  o_rsp_data;
  logic        o_rsp_last;
  logic        o_busy;

  int checks = 0;
  int failures = 0;
  int cur_row = -1;

  rom_burst_arbiter #(.WIDTH(8), .DEPTH(128), .NUM_REQ(2), .LEN_W(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .o_req_ready(o_req_ready), .o_rom_addr(o_rom_addr), .i_rom_dout(i_rom_dout),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data),
    .o_rsp_last(o_rsp_last), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] rom_val(input logic [6:0] a);
    return (a == 7'h10) ? 8'hA5 : 8'({1'b0, a} * 8'd7 + 8'd3);
  endfunction

  // ROM model: registered read, 1-cycle latency.
  always @(posedge i_clk) i_rom_dout <= rom_val(o_rom_addr);

  typedef struct packed {
    logic [1:0] v;
    logic [6:0] a0, a1;
    logic [3:0] l0, l1;
    logic [1:0] rdy;
    logic [6:0] addr;
    logic       busy, iv, id, last;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] v, input logic [6:0] a0, a1,
                              input logic [3:0] l0, l1, input logic [1:0] rdy,
                              input logic [6:0] addr, input logic busy, iv, id, last);
    vec_t r;
    r.v = v; r.a0 = a0; r.a1 = a1; r.l0 = l0; r.l1 = l1;
    r.rdy = rdy; r.addr = addr; r.busy = busy; r.iv = iv; r.id = id; r.last = last;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, cur_row, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    i_req_valid = r.v;
    i_req_addr  = {r.a1, r.a0};
    i_req_len   = {r.l1, r.l0};
  endtask

  initial begin
    vec_t p;
    //               v     a0     a1     l0 l1  rdy   addr  bsy iv id last
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(2'd1, 7'h10, 7'h00, 0, 0, 2'd1, 7'h10, 0, 1, 0, 1)); // single word
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(2'd2, 7'h00, 7'h05, 0, 3, 2'd2, 7'h05, 0, 1, 1, 0)); // burst len 3
    tbl.push_back(mk(2'd0, 7'h00, 7'h05, 0, 3, 2'd0, 7'h06, 1, 1, 1, 0));
    tbl.push_back(mk(2'd0, 7'h00, 7'h05, 0, 3, 2'd0, 7'h07, 1, 1, 1, 0));
    tbl.push_back(mk(2'd0, 7'h00, 7'h05, 0, 3, 2'd0, 7'h08, 1, 1, 1, 1));
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(2'd3, 7'h20, 7'h30, 0, 0, 2'd1, 7'h20, 0, 1, 0, 1)); // round robin
    tbl.push_back(mk(2'd3, 7'h20, 7'h30, 0, 0, 2'd2, 7'h30, 0, 1, 1, 1));
    tbl.push_back(mk(2'd3, 7'h20, 7'h30, 0, 0, 2'd1, 7'h20, 0, 1, 0, 1));
    tbl.push_back(mk(2'd3, 7'h20, 7'h30, 0, 0, 2'd2, 7'h30, 0, 1, 1, 1));
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(2'd1, 7'h7E, 7'h00, 3, 0, 2'd1, 7'h7E, 0, 1, 0, 0)); // wrap
    tbl.push_back(mk(2'd0, 7'h7E, 7'h00, 3, 0, 2'd0, 7'h7F, 1, 1, 0, 0));
    tbl.push_back(mk(2'd3, 7'h50, 7'h40, 0, 1, 2'd0, 7'h00, 1, 1, 0, 0)); // requests wait
    tbl.push_back(mk(2'd3, 7'h50, 7'h40, 0, 1, 2'd0, 7'h01, 1, 1, 0, 1));
    tbl.push_back(mk(2'd3, 7'h50, 7'h40, 0, 1, 2'd2, 7'h40, 0, 1, 1, 0)); // no bubble, rr=1
    tbl.push_back(mk(2'd1, 7'h50, 7'h40, 0, 1, 2'd0, 7'h41, 1, 1, 1, 1));
    tbl.push_back(mk(2'd1, 7'h50, 7'h40, 0, 1, 2'd1, 7'h50, 0, 1, 0, 1));
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));
    tbl.push_back(mk(2'd0, 7'h00, 7'h00, 0, 0, 2'd0, 7'h00, 0, 0, 0, 0));

    // Reset state, with a request present: no grant may leak out.
    i_req_valid = 2'b01; i_req_addr = {7'h00, 7'h10};
    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(o_req_ready), 32'(0));
    check("rst_rom_addr", 32'(o_rom_addr), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'(0));
    check("rst_rsp_id", 32'(o_rsp_id), 32'(0));
    check("rst_rsp_data", 32'(o_rsp_data), 32'(0));
    check("rst_rsp_last", 32'(o_rsp_last), 32'(0));
    i_req_valid = '0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge i_clk); #1;
      drive(tbl[k]);
      cur_row = k;
      @(negedge i_clk);
      check("ready", 32'(o_req_ready), 32'(tbl[k].rdy));
      check("rom_addr", 32'(o_rom_addr), 32'(tbl[k].addr));
      check("busy", 32'(o_busy), 32'(tbl[k].busy));
      if (k >= LAT) begin
        p = tbl[k-LAT];
        check("rsp_valid", 32'(o_rsp_valid), 32'(p.iv));
        if (p.iv) begin
          check("rsp_id", 32'(o_rsp_id), 32'(p.id));
          check("rsp_data", 32'(o_rsp_data), 32'(rom_val(p.addr)));
          check("rsp_last", 32'(o_rsp_last), 32'(p.last));
        end
      end else begin
        check("rsp_valid", 32'(o_rsp_valid), 32'(0));
      end
    end

    // Reset mid-burst: requester 0, len 7, reset at the third issue.
    cur_row = 100;
    @(posedge i_clk); #1;
    i_req_valid = 2'b01; i_req_addr = {7'h00, 7'h60}; i_req_len = {4'd0, 4'd7};
    @(negedge i_clk);
    check("mb_ready", 32'(o_req_ready), 32'(1));
    check("mb_addr0", 32'(o_rom_addr), 32'(7'h60));
    @(posedge i_clk); #1 i_req_valid = 2'b00;
    @(negedge i_clk);
    check("mb_addr1", 32'(o_rom_addr), 32'(7'h61));
    check("mb_busy", 32'(o_busy), 32'(1));
    @(posedge i_clk); #1;
    i_req_valid = 2'b11; i_req_addr = {7'h71, 7'h70}; i_req_len = 8'd0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    cur_row = 101;
    check("mb_rst_ready", 32'(o_req_ready), 32'(0));
    check("mb_rst_addr", 32'(o_rom_addr), 32'(0));
    check("mb_rst_busy", 32'(o_busy), 32'(0));
    check("mb_rst_valid", 32'(o_rsp_valid), 32'(0));
    check("mb_rst_id", 32'(o_rsp_id), 32'(0));
    check("mb_rst_data", 32'(o_rsp_data), 32'(0));
    check("mb_rst_last", 32'(o_rsp_last), 32'(0));
    @(negedge i_clk);
    cur_row = 102;
    check("mb_hold_ready", 32'(o_req_ready), 32'(0));
    check("mb_hold_valid", 32'(o_rsp_valid), 32'(0));
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    cur_row = 103;
    check("post_rst_ready", 32'(o_req_ready), 32'(1));
    check("post_rst_addr", 32'(o_rom_addr), 32'(7'h70));
    @(posedge i_clk); #1 i_req_valid = 2'b00;
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) begin @(posedge i_clk); #1; end
      @(negedge i_clk);
      cur_row = 103 + c;
      check("post_rst_rsp_valid", 32'(o_rsp_valid), 32'(c == LAT));
      if (c == LAT) begin
        check("post_rst_rsp_id", 32'(o_rsp_id), 32'(0));
        check("post_rst_rsp_data", 32'(o_rsp_data), 32'(rom_val(7'h70)));
        check("post_rst_rsp_last", 32'(o_rsp_last), 32'(1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_burst_arbiter.md
# rom_burst_arbiter

Shares one synchronous single-port ROM (registered read data, 1-cycle latency) between NUM_REQ requesters. Each requester asks for a burst of consecutive words. A round-robin arbiter grants one burst at a time. The block then sequences the ROM address, one word per cycle, and returns tagged read data. It sits between font/pattern/lookup consumers and the ROM instance.

## Interface
- WIDTH, 8: ROM data width.
- DEPTH, 128: ROM word count. Need not be a power of two.
- NUM_REQ, 2: number of requesters (≥2).
- LEN_W, 4: burst length field width. Field value is words−1.
- AW: derived, $clog2(DEPTH).
- IDW: derived, $clog2(NUM_REQ).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  NUM_REQ  per-requester burst request
- i_req_addr  in  NUM_REQ*AW  start address; requester k at bits [k*AW +: AW]
- i_req_len  in  NUM_REQ*LEN_W  burst length minus 1; requester k at [k*LEN_W +: LEN_W]
- o_req_ready  out  NUM_REQ  one-hot grant pulse; request accepted this cycle
- o_rom_addr  out  AW  to ROM read address
- i_rom_dout  in  WIDTH  from ROM read data
- o_rsp_valid  out  1  read word valid
- o_rsp_id  out  IDW  requester owning o_rsp_data
- o_rsp_data  out  WIDTH  read word
- o_rsp_last  out  1  final word of burst
- o_busy  out  1  burst in progress (state BURST)

## Operation
- FSM states: IDLE and BURST. Reset state is IDLE.
- Requesters hold valid, addr and len stable until they see ready. The block samples them only in the grant cycle.
- **IDLE, no valid:** issue nothing; o_rom_addr = 0.
- **IDLE, any valid set:**
  - Winner = first set i_req_valid bit searching cyclically from rr_ptr.
  - o_req_ready[winner] = 1, combinational, same cycle.
  - o_rom_addr = winner's addr; this issues word 0.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - If len == 0: stay in IDLE. Issued word is last.
  - Else: go to BURST with cur_addr <= addr+1 (wrapped), remaining <= len, owner <= winner.
- **BURST:**
  - o_rom_addr = cur_addr; issue one word per cycle.
  - cur_addr increments with wrap: DEPTH−1 → 0.
  - remaining decrements.
  - When remaining == 1, this issue is last and the next state is IDLE.
- Requests arriving during BURST wait. No preemption. o_req_ready is 0 in BURST.
- Back-to-back bursts have no bubble: the cycle after the last BURST issue is an IDLE grant cycle.
- Issue tracking register (issue_v, id, last) is clocked every cycle and delayed 1 cycle to align with ROM latency.
- Response outputs:
  - o_rsp_valid = issue_v_d
  - o_rsp_id = id_d
  - o_rsp_last = last_d
  - o_rsp_data = i_rom_dout
- Consumers cannot stall responses.
- Address arithmetic: AW-bit. Wrap is by explicit compare to DEPTH−1, not by natural overflow.

## Timing
- Reset values: o_req_ready=0, o_rom_addr=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_rsp_last=0, o_busy=0, rr_ptr=0, internal counters 0.
- Reset asserted mid-burst aborts immediately: FSM to IDLE, pending responses dropped (o_rsp_valid=0). No ready is issued while in reset.
- Grant cycle T: ready and first address in cycle T. Word 0 appears on o_rsp_* in cycle T+1.
- A burst of len+1 words occupies cycles T..T+len at the ROM. Responses appear in T+1..T+len+1, contiguous, with last on the final word.
- o_busy is high in cycles T+1..T+len, and only when len>0.
- Throughput: one word per cycle, sustained across bursts.

## Configuration
- ROM_BURST_ARB_RSP_REG_EN defined: o_rsp_valid/id/data/last pass through one extra output register, all reset to 0. Response latency becomes 2 cycles after issue, which eases timing into consumers.
- Undefined: latency is 1 cycle and o_rsp_data is a direct combinational path from i_rom_dout.

## Test plan
- **Single word:** req0 valid, addr=0x10, len=0, ROM[0x10]=0xA5 → ready0 high at T. o_rsp_valid, id=0, data=0xA5, last=1 at T+1. o_busy stays 0.
- **Burst:** req1 addr=5, len=3 → o_rom_addr 5,6,7,8 in T..T+3. Four responses id=1 in T+1..T+4, last only at T+4. o_busy high T+1..T+3.
- **Round robin:** both valid, len=0, held → grants alternate 0,1,0,1 on consecutive cycles. Responses stream with no gap.
- **Wrap:** DEPTH=128, addr=126, len=3 → addresses 126,127,0,1.
- **Reset mid-burst:** len=7, pull i_rst_n low at third issue → all outputs 0 immediately. After release, a fresh request is granted to requester 0 (rr_ptr=0).
- **Macro defined:** repeat the burst case → identical data and flags, each shifted one cycle later (T+2..T+5).
